// File: rtl/rf_pkg.sv
// Shared register-file definitions: widths, the zero register, the arbiter
// FSM encoding and small index helpers.
package rf_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 32;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [0:0] {
        S_NORM  = 1'b0,
        S_FORCE = 1'b1
    } arb_state_t;

    // One-hot mask selecting register idx.
    function automatic logic [NREG-1:0] reg_onehot(input logic [REG_W-1:0] idx);
        reg_onehot = {{(NREG-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Register 0 is hard-wired; every other index is writable.
    function automatic logic is_writable(input logic [REG_W-1:0] idx);
        is_writable = (idx != REG_ZERO);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy mask of registers awaiting multi-cycle results.
// A set and a clear of the same bit on the same edge leave the bit set.
// Bit 0 never becomes busy.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [REG_W-1:0] clr_idx,
    output logic [NREG-1:0]  busy
);

    logic [NREG-1:0] busy_r;
    logic [NREG-1:0] set_mask_s;
    logic [NREG-1:0] clr_mask_s;
    logic [NREG-1:0] busy_nxt_s;

    // Build set/clear masks and the next busy vector (set has priority).
    always_comb begin
        set_mask_s = {NREG{1'b0}};
        clr_mask_s = {NREG{1'b0}};
        if (set_en && is_writable(set_idx)) begin
            set_mask_s = reg_onehot(set_idx);
        end else begin
            set_mask_s = {NREG{1'b0}};
        end
        if (clr_en) begin
            clr_mask_s = reg_onehot(clr_idx);
        end else begin
            clr_mask_s = {NREG{1'b0}};
        end
        busy_nxt_s    = (busy_r & ~clr_mask_s) | set_mask_s;
        busy_nxt_s[0] = 1'b0;
    end

    // Busy mask register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= {NREG{1'b0}};
        end else begin
            busy_r <= busy_nxt_s;
        end
    end

    assign busy = busy_r;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, the
// multi-cycle unit is served through valid/ready and is guaranteed a slot
// after MAX_WAIT consecutive refusals by stalling the pipeline for one cycle.
// Also tracks which registers still await a multi-cycle result.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 4
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              P_WE,
    input  logic [REG_W-1:0]  P_A3,
    input  logic [DATA_W-1:0] P_WD,
    input  logic              M_Valid,
    input  logic [REG_W-1:0]  M_A3,
    input  logic [DATA_W-1:0] M_WD,
    output logic              M_Ready,
    input  logic              M_Issue,
    input  logic [REG_W-1:0]  M_IssueA3,
    output logic              Stall,
    output logic              RFWr,
    output logic [REG_W-1:0]  A3,
    output logic [DATA_W-1:0] WD,
    output logic [NREG-1:0]   Busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    arb_state_t        state_r;
    arb_state_t        state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic              grant_p_s;
    logic              grant_m_s;
    logic              m_ready_s;
    logic              wr_en_s;
    logic [REG_W-1:0]  wr_a3_s;
    logic [DATA_W-1:0] wr_wd_s;

    logic              stall_r;
    logic              rfwr_r;
    logic [REG_W-1:0]  a3_r;
    logic [DATA_W-1:0] wd_r;
    logic              m_wr_r;

    assign cnt_inc_s = cnt_r + CNT_ONE;

    // Arbitration decision, wait counter update and next FSM state.
    always_comb begin
        state_nxt_s = S_NORM;
        cnt_nxt_s   = {CNT_W{1'b0}};
        grant_p_s   = 1'b0;
        grant_m_s   = 1'b0;
        m_ready_s   = 1'b0;
        case (state_r)
            S_NORM: begin
                if (P_WE) begin
                    grant_p_s = 1'b1;
                end else if (M_Valid) begin
                    grant_m_s = 1'b1;
                    m_ready_s = 1'b1;
                end else begin
                    grant_p_s = 1'b0;
                end
                if (M_Valid && !m_ready_s) begin
                    if (cnt_inc_s == CNT_MAX) begin
                        state_nxt_s = S_FORCE;
                        cnt_nxt_s   = {CNT_W{1'b0}};
                    end else begin
                        cnt_nxt_s   = cnt_inc_s;
                    end
                end else begin
                    cnt_nxt_s = {CNT_W{1'b0}};
                end
            end
            S_FORCE: begin
                // Pipeline request is ignored; it is re-presented next cycle.
                if (M_Valid) begin
                    grant_m_s = 1'b1;
                    m_ready_s = 1'b1;
                end else begin
                    grant_m_s = 1'b0;
                end
                state_nxt_s = S_NORM;
            end
            default: begin
                state_nxt_s = S_NORM;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Select the address/data of whichever source won the port.
    always_comb begin
        wr_en_s = grant_p_s | grant_m_s;
        if (grant_p_s) begin
            wr_a3_s = P_A3;
            wr_wd_s = P_WD;
        end else begin
            wr_a3_s = M_A3;
            wr_wd_s = M_WD;
        end
    end

    // FSM state, wait counter and registered write-port outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r <= S_NORM;
            cnt_r   <= {CNT_W{1'b0}};
            stall_r <= 1'b0;
            rfwr_r  <= 1'b0;
            a3_r    <= {REG_W{1'b0}};
            wd_r    <= {DATA_W{1'b0}};
            m_wr_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            stall_r <= (state_nxt_s == S_FORCE);
            if (wr_en_s) begin
                rfwr_r <= is_writable(wr_a3_s);
                a3_r   <= wr_a3_s;
                wd_r   <= wr_wd_s;
            end else begin
                rfwr_r <= 1'b0;
            end
            // Remembers that the pending RF write retires a multi-cycle result.
            m_wr_r <= grant_m_s && is_writable(M_A3);
        end
    end

    // Busy falls on the edge that commits the multi-cycle result into the RF.
    rf_scoreboard u_scoreboard (
        .clk     (Clk),
        .rst_n   (Rst_n),
        .set_en  (M_Issue),
        .set_idx (M_IssueA3),
        .clr_en  (m_wr_r),
        .clr_idx (a3_r),
        .busy    (Busy)
    );

    assign M_Ready = m_ready_s & Rst_n;
    assign Stall   = stall_r;
    assign RFWr    = rfwr_r;
    assign A3      = a3_r;
    assign WD      = wd_r;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (MAX_WAIT = 4).
module tb_rf_wb_arbiter;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        P_WE;
    logic [4:0]  P_A3;
    logic [31:0] P_WD;
    logic        M_Valid;
    logic [4:0]  M_A3;
    logic [31:0] M_WD;
    logic        M_Ready;
    logic        M_Issue;
    logic [4:0]  M_IssueA3;
    logic        Stall;
    logic        RFWr;
    logic [4:0]  A3;
    logic [31:0] WD;
    logic [31:0] Busy;

    int n_checks = 0;
    int n_fail   = 0;

    rf_wb_arbiter #(.MAX_WAIT(4), .CNT_W(4)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .P_WE      (P_WE),
        .P_A3      (P_A3),
        .P_WD      (P_WD),
        .M_Valid   (M_Valid),
        .M_A3      (M_A3),
        .M_WD      (M_WD),
        .M_Ready   (M_Ready),
        .M_Issue   (M_Issue),
        .M_IssueA3 (M_IssueA3),
        .Stall     (Stall),
        .RFWr      (RFWr),
        .A3        (A3),
        .WD        (WD),
        .Busy      (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs;
        P_WE = 1'b0; P_A3 = 5'd0; P_WD = 32'd0;
        M_Valid = 1'b0; M_A3 = 5'd0; M_WD = 32'd0;
        M_Issue = 1'b0; M_IssueA3 = 5'd0;
    endtask

    initial begin
        int phase;
        Rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge Clk);
        #1;

        // ---- reset release and first pipeline write ----
        Rst_n = 1'b1;
        P_WE = 1'b1; P_A3 = 5'd3; P_WD = 32'h11;
        #1;
        chk("first_mready", 32'(M_Ready), 32'd0);
        tick();
        chk("first_rfwr", 32'(RFWr), 32'd1);
        chk("first_a3", 32'(A3), 32'd3);
        chk("first_wd", WD, 32'h11);
        P_WE = 1'b0;
        M_Issue = 1'b1; M_IssueA3 = 5'd7;
        tick();
        M_Issue = 1'b0;
        chk("pre_rst_busy", Busy, 32'h80);

        // ---- asynchronous reset mid-cycle ----
        M_Valid = 1'b1; M_A3 = 5'd8; M_WD = 32'h88;
        #3;
        Rst_n = 1'b0;
        #1;
        chk("rst_rfwr", 32'(RFWr), 32'd0);
        chk("rst_a3", 32'(A3), 32'd0);
        chk("rst_wd", WD, 32'd0);
        chk("rst_stall", 32'(Stall), 32'd0);
        chk("rst_busy", Busy, 32'd0);
        chk("rst_mready", 32'(M_Ready), 32'd0);
        idle_inputs();
        tick();
        chk("rst_no_write", 32'(RFWr), 32'd0);
        Rst_n = 1'b1;
        tick();

        // ---- priority: P beats M ----
        P_WE = 1'b1; P_A3 = 5'd5; P_WD = 32'h55;
        M_Valid = 1'b1; M_A3 = 5'd6; M_WD = 32'h66;
        #1;
        chk("prio_mready0", 32'(M_Ready), 32'd0);
        tick();
        chk("prio_p_a3", 32'(A3), 32'd5);
        chk("prio_p_wd", WD, 32'h55);
        P_WE = 1'b0;
        #1;
        chk("prio_mready1", 32'(M_Ready), 32'd1);
        tick();
        chk("prio_m_rfwr", 32'(RFWr), 32'd1);
        chk("prio_m_a3", 32'(A3), 32'd6);
        chk("prio_m_wd", WD, 32'h66);
        M_Valid = 1'b0;
        tick();
        chk("idle_rfwr", 32'(RFWr), 32'd0);
        chk("idle_a3_hold", 32'(A3), 32'd6);

        // ---- starvation: forced slot every 5th cycle ----
        P_WE = 1'b1; P_A3 = 5'd10; P_WD = 32'h0A;
        M_Valid = 1'b1; M_A3 = 5'd12; M_WD = 32'h0C;
        #1;
        for (int c = 0; c < 10; c++) begin
            phase = c % 5;
            chk("starve_stall", 32'(Stall), 32'(phase == 4));
            chk("starve_mready", 32'(M_Ready), 32'(phase == 4));
            tick();
            chk("starve_rfwr", 32'(RFWr), 32'd1);
            chk("starve_a3", 32'(A3), (phase == 4) ? 32'd12 : 32'd10);
        end
        idle_inputs();
        tick();
        chk("starve_end_stall", 32'(Stall), 32'd0);
        chk("starve_end_rfwr", 32'(RFWr), 32'd0);

        // ---- register zero: handshake completes, no write, counter clears ----
        P_WE = 1'b1; P_A3 = 5'd11; P_WD = 32'hB;
        M_Valid = 1'b1; M_A3 = 5'd0; M_WD = 32'hDEAD;
        tick();
        tick();
        P_WE = 1'b0;
        #1;
        chk("r0_mready", 32'(M_Ready), 32'd1);
        tick();
        chk("r0_rfwr", 32'(RFWr), 32'd0);
        P_WE = 1'b1; M_A3 = 5'd4; M_WD = 32'h44;
        #1;
        for (int c = 0; c < 4; c++) begin
            chk("r0_cnt_stall", 32'(Stall), 32'd0);
            chk("r0_cnt_mready", 32'(M_Ready), 32'd0);
            tick();
        end
        chk("r0_cnt_force", 32'(Stall), 32'd1);
        idle_inputs();
        tick();
        tick();

        // ---- scoreboard set / clear / set-wins ----
        chk("sb_pre_issue_free", 32'(Busy[9]), 32'd0);
        M_Issue = 1'b1; M_IssueA3 = 5'd9;
        tick();
        M_Issue = 1'b0;
        chk("sb_set", Busy, 32'h200);
        M_Valid = 1'b1; M_A3 = 5'd9; M_WD = 32'h99;
        #1;
        chk("sb_mready", 32'(M_Ready), 32'd1);
        tick();
        M_Valid = 1'b0;
        chk("sb_busy_n1", Busy, 32'h200);
        chk("sb_rfwr_n1", 32'(RFWr), 32'd1);
        chk("sb_a3_n1", 32'(A3), 32'd9);
        tick();
        chk("sb_clear_n2", Busy, 32'd0);
        M_Issue = 1'b1; M_IssueA3 = 5'd9;
        tick();
        M_Issue = 1'b0;
        M_Valid = 1'b1; M_A3 = 5'd9; M_WD = 32'h9A;
        tick();
        M_Valid = 1'b0;
        M_Issue = 1'b1; M_IssueA3 = 5'd9;
        tick();
        M_Issue = 1'b0;
        chk("sb_set_wins", Busy, 32'h200);
        M_Issue = 1'b1; M_IssueA3 = 5'd0;
        tick();
        M_Issue = 1'b0;
        chk("sb_bit0", Busy, 32'h200);

        // ---- back-to-back M writes ----
        for (int i = 1; i <= 3; i++) begin
            M_Valid = 1'b1; M_A3 = 5'(i); M_WD = 32'h100 + 32'(i);
            #1;
            chk("b2b_mready", 32'(M_Ready), 32'd1);
            tick();
            chk("b2b_rfwr", 32'(RFWr), 32'd1);
            chk("b2b_a3", 32'(A3), 32'(i));
            chk("b2b_wd", WD, 32'h100 + 32'(i));
        end
        M_Valid = 1'b0;
        tick();
        chk("b2b_end_rfwr", 32'(RFWr), 32'd0);

        // ---- M_Valid dropping while refused clears the counter ----
        P_WE = 1'b1; P_A3 = 5'd13; P_WD = 32'hD;
        M_Valid = 1'b1; M_A3 = 5'd14; M_WD = 32'hE;
        tick(); tick(); tick();
        M_Valid = 1'b0;
        tick();
        M_Valid = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            chk("drop_stall", 32'(Stall), 32'd0);
            tick();
        end
        chk("drop_force", 32'(Stall), 32'd1);
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
